reg_bus_xfer: RTL and testbench

//   Parametrised register-file bus: N_REGS registers of WIDTH bits share one bus.

---
 rtl/reg_bus_xfer_if.sv | 40 ++++
 rtl/reg_bus_xfer.sv | 128 ++++++++++++
 tb/tb_reg_bus_xfer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/reg_bus_xfer_if.sv
// Handshake, load, read and bus-observation signals of reg_bus_xfer.
// REG_BUS_PARITY_EN adds the registered bus parity output bus_par.
interface reg_bus_xfer_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             ld_en;
    logic [SEL_W-1:0] ld_sel;
    logic [WIDTH-1:0] ld_data;
    logic             xfer_valid;
    logic             xfer_ready;
    logic [SEL_W-1:0] src_sel;
    logic [SEL_W-1:0] dst_sel;
    logic [SEL_W-1:0] rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] bus_out;
    logic             done;
    logic             err;
`ifdef REG_BUS_PARITY_EN
    logic             bus_par;

    modport master (
        output ld_en, ld_sel, ld_data, xfer_valid, src_sel, dst_sel, rd_sel,
        input  xfer_ready, rd_data, bus_out, done, err, bus_par
    );
    modport slave (
        input  ld_en, ld_sel, ld_data, xfer_valid, src_sel, dst_sel, rd_sel,
        output xfer_ready, rd_data, bus_out, done, err, bus_par
    );
`else
    modport master (
        output ld_en, ld_sel, ld_data, xfer_valid, src_sel, dst_sel, rd_sel,
        input  xfer_ready, rd_data, bus_out, done, err
    );
    modport slave (
        input  ld_en, ld_sel, ld_data, xfer_valid, src_sel, dst_sel, rd_sel,
        output xfer_ready, rd_data, bus_out, done, err
    );
`endif
endinterface

// File: rtl/reg_bus_xfer.sv
// Register file with a shared registered bus: IDLE -> BUS -> WB register-to-register moves.
// Optional REG_BUS_PARITY_EN stores a parity bit per register and drives bus_par.
module reg_bus_xfer #(
    parameter int WIDTH  = 8,
    parameter int N_REGS = 6,
    parameter int SEL_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    reg_bus_xfer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [N_REGS];
    logic [WIDTH-1:0] regs_d [N_REGS];
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef REG_BUS_PARITY_EN
    logic             par_q [N_REGS];
    logic             par_d [N_REGS];
    logic             bus_par_q, bus_par_d;
`endif

    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return int'(s) < N_REGS;
    endfunction

    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        src_d   = src_q;
        dst_d   = dst_q;
        bus_d   = bus_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef REG_BUS_PARITY_EN
        par_d     = par_q;
        bus_par_d = bus_par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.xfer_valid) begin
                    if (sel_ok(bus.src_sel) && sel_ok(bus.dst_sel)) begin
                        src_d   = bus.src_sel;
                        dst_d   = bus.dst_sel;
                        state_d = BUS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BUS: begin
                // Reads regs_q, so a same-edge load to src_q is not seen on the bus.
                bus_d   = regs_q[src_q];
                state_d = WB;
`ifdef REG_BUS_PARITY_EN
                bus_par_d = ^regs_q[src_q];
                if ((^regs_q[src_q]) != par_q[src_q]) err_d = 1'b1;
`endif
            end
            WB: begin
                regs_d[dst_q] = bus_q;
`ifdef REG_BUS_PARITY_EN
                par_d[dst_q] = ^bus_q;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Applied after write-back so an external load to the same register wins.
        if (bus.ld_en) begin
            if (sel_ok(bus.ld_sel)) begin
                regs_d[bus.ld_sel] = bus.ld_data;
`ifdef REG_BUS_PARITY_EN
                par_d[bus.ld_sel] = ^bus.ld_data;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            regs_q  <= '{default: '0};
            src_q   <= '0;
            dst_q   <= '0;
            bus_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef REG_BUS_PARITY_EN
            par_q     <= '{default: 1'b0};
            bus_par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            bus_q   <= bus_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef REG_BUS_PARITY_EN
            par_q     <= par_d;
            bus_par_q <= bus_par_d;
`endif
        end
    end

    assign bus.xfer_ready = (state_q == IDLE);
    assign bus.rd_data    = sel_ok(bus.rd_sel) ? regs_q[bus.rd_sel] : '0;
    assign bus.bus_out    = bus_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
`ifdef REG_BUS_PARITY_EN
    assign bus.bus_par    = bus_par_q;
`endif
endmodule

// File: tb/tb_reg_bus_xfer.sv
// Directed vector bench for reg_bus_xfer: one table row per clock edge, plus reset and parity sequences.
module tb_reg_bus_xfer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_bus_xfer_if #(.WIDTH(8), .SEL_W(3)) bus_if ();

    reg_bus_xfer #(.WIDTH(8), .N_REGS(6), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic       ld_en;
        logic [2:0] ld_sel;
        logic [7:0] ld_data;
        logic       xv;
        logic [2:0] src;
        logic [2:0] dst;
        logic [2:0] rd;
        logic [7:0] e_rd;
        logic       e_rdy;
        logic       e_done;
        logic       e_err;
        logic [7:0] e_bus;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic le, input logic [2:0] ls, input logic [7:0] ld,
                       input logic xv, input logic [2:0] s, input logic [2:0] d,
                       input logic [2:0] r, input logic [7:0] erd, input logic erdy,
                       input logic edone, input logic eerr, input logic [7:0] ebus);
        vec_t v;
        v.ld_en = le; v.ld_sel = ls; v.ld_data = ld; v.xv = xv; v.src = s; v.dst = d;
        v.rd = r; v.e_rd = erd; v.e_rdy = erdy; v.e_done = edone; v.e_err = eerr; v.e_bus = ebus;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic le, input logic [2:0] ls, input logic [7:0] ld,
                         input logic xv, input logic [2:0] s, input logic [2:0] d,
                         input logic [2:0] r);
        bus_if.ld_en = le; bus_if.ld_sel = ls; bus_if.ld_data = ld;
        bus_if.xfer_valid = xv; bus_if.src_sel = s; bus_if.dst_sel = d; bus_if.rd_sel = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            bus_if.rd_sel = 3'(i);
            #1;
            chk($sformatf("reset_rd%0d", i), 32'(bus_if.rd_data), 32'h0);
        end
        chk("reset_ready", 32'(bus_if.xfer_ready), 32'h1);
        chk("reset_done",  32'(bus_if.done), 32'h0);
        chk("reset_err",   32'(bus_if.err), 32'h0);
        chk("reset_bus",   32'(bus_if.bus_out), 32'h0);

        // le ls  ld     xv s  d  rd  e_rd   rdy dn er e_bus
        add(1, 0, 8'h01, 0, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00);
        add(1, 1, 8'h02, 0, 0, 0, 1, 8'h02, 1, 0, 0, 8'h00);
        add(1, 2, 8'h03, 0, 0, 0, 2, 8'h03, 1, 0, 0, 8'h00);
        add(1, 3, 8'h04, 0, 0, 0, 3, 8'h04, 1, 0, 0, 8'h00);
        add(1, 4, 8'h05, 0, 0, 0, 4, 8'h05, 1, 0, 0, 8'h00);
        add(1, 5, 8'h06, 0, 0, 0, 5, 8'h06, 1, 0, 0, 8'h00);
        add(1, 6, 8'hFF, 0, 0, 0, 6, 8'h00, 1, 0, 1, 8'h00);
        add(0, 0, 8'h00, 1, 2, 5, 5, 8'h06, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 5, 8'h06, 0, 0, 0, 8'h03);
        add(0, 0, 8'h00, 0, 0, 0, 5, 8'h03, 1, 1, 0, 8'h03);
        add(0, 0, 8'h00, 0, 0, 0, 5, 8'h03, 1, 0, 0, 8'h03);
        add(0, 0, 8'h00, 1, 6, 0, 0, 8'h01, 1, 0, 1, 8'h03);
        add(0, 0, 8'h00, 1, 0, 7, 7, 8'h00, 1, 0, 1, 8'h03);
        add(0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 1, 0, 0, 8'h03);
        add(0, 0, 8'h00, 1, 1, 4, 4, 8'h05, 0, 0, 0, 8'h03);
        add(0, 0, 8'h00, 0, 0, 0, 4, 8'h05, 0, 0, 0, 8'h02);
        add(1, 4, 8'hAA, 0, 0, 0, 4, 8'hAA, 1, 1, 0, 8'h02);
        add(0, 0, 8'h00, 0, 0, 0, 4, 8'hAA, 1, 0, 0, 8'h02);
        add(0, 0, 8'h00, 1, 3, 3, 3, 8'h04, 0, 0, 0, 8'h02);
        add(0, 0, 8'h00, 0, 0, 0, 3, 8'h04, 0, 0, 0, 8'h04);
        add(0, 0, 8'h00, 0, 0, 0, 3, 8'h04, 1, 1, 0, 8'h04);
        add(0, 0, 8'h00, 1, 0, 1, 1, 8'h02, 0, 0, 0, 8'h04);
        add(1, 0, 8'h55, 0, 0, 0, 0, 8'h55, 0, 0, 0, 8'h01);
        add(0, 0, 8'h00, 0, 0, 0, 1, 8'h01, 1, 1, 0, 8'h01);
        add(0, 0, 8'h00, 1, 5, 3, 3, 8'h04, 0, 0, 0, 8'h01);
        add(1, 7, 8'h00, 1, 5, 3, 3, 8'h04, 0, 0, 1, 8'h03);
        add(1, 6, 8'h00, 1, 5, 3, 3, 8'h03, 1, 1, 1, 8'h03);
        add(0, 0, 8'h00, 1, 0, 3, 3, 8'h03, 0, 0, 0, 8'h03);
        add(0, 0, 8'h00, 0, 0, 0, 3, 8'h03, 0, 0, 0, 8'h55);
        add(0, 0, 8'h00, 0, 0, 0, 3, 8'h55, 1, 1, 0, 8'h55);

        foreach (vecs[k]) begin
            drive(vecs[k].ld_en, vecs[k].ld_sel, vecs[k].ld_data,
                  vecs[k].xv, vecs[k].src, vecs[k].dst, vecs[k].rd);
            step();
            chk($sformatf("v%0d_rd", k),    32'(bus_if.rd_data),    32'(vecs[k].e_rd));
            chk($sformatf("v%0d_ready", k), 32'(bus_if.xfer_ready), 32'(vecs[k].e_rdy));
            chk($sformatf("v%0d_done", k),  32'(bus_if.done),       32'(vecs[k].e_done));
            chk($sformatf("v%0d_err", k),   32'(bus_if.err),        32'(vecs[k].e_err));
            chk($sformatf("v%0d_bus", k),   32'(bus_if.bus_out),    32'(vecs[k].e_bus));
        end

        // Reset while in BUS aborts the transfer
        drive(0, 0, 0, 1, 4, 0, 0);
        step();
        chk("abort_accept_ready", 32'(bus_if.xfer_ready), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("abort_ready", 32'(bus_if.xfer_ready), 32'h1);
        chk("abort_done",  32'(bus_if.done), 32'h0);
        chk("abort_bus",   32'(bus_if.bus_out), 32'h0);
        for (int i = 0; i < 6; i++) begin
            bus_if.rd_sel = 3'(i);
            #1;
            chk($sformatf("abort_rd%0d", i), 32'(bus_if.rd_data), 32'h0);
        end
        rst = 1'b0;
        bus_if.rd_sel = 3'd0;
        step();
        chk("abort_done_p1", 32'(bus_if.done), 32'h0);
        step();
        chk("abort_done_p2", 32'(bus_if.done), 32'h0);
        chk("abort_reg0",    32'(bus_if.rd_data), 32'h0);
        chk("abort_ready_p2", 32'(bus_if.xfer_ready), 32'h1);

`ifdef REG_BUS_PARITY_EN
        drive(1, 0, 8'h07, 0, 0, 0, 0); step();
        drive(1, 1, 8'h03, 0, 0, 0, 0); step();
        drive(0, 0, 8'h00, 1, 0, 2, 2); step();
        drive(0, 0, 8'h00, 0, 0, 0, 2); step();
        chk("par_bus07", 32'(bus_if.bus_out), 32'h07);
        chk("par_07",    32'(bus_if.bus_par), 32'h1);
        chk("par_err07", 32'(bus_if.err), 32'h0);
        step();
        drive(0, 0, 8'h00, 1, 1, 2, 2); step();
        drive(0, 0, 8'h00, 0, 0, 0, 2); step();
        chk("par_bus03", 32'(bus_if.bus_out), 32'h03);
        chk("par_03",    32'(bus_if.bus_par), 32'h0);
        step();
        chk("par_done03", 32'(bus_if.done), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
